// File: rtl/wb_active_pkg.sv
// wb_active_pkg: register offsets, status bits and FSM encoding shared by wb_active_ctrl
package wb_active_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, APPLY = 2'd2} state_t;
  localparam logic [7:0] OFF_REQ = 8'h00;
  localparam logic [7:0] OFF_CUR = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_ID = 8'h0C;
  localparam int ST_BUSY = 0;
  localparam int ST_PEND = 1;
endpackage

// File: rtl/wb_slave_if.sv
// wb_slave_if: wishbone hit decode, single-cycle registered ack and read mux
module wb_slave_if
  import wb_active_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        cyc,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] req,
  input  logic [31:0] cur,
  input  logic [31:0] status,
  input  logic [31:0] id,
  output logic        ack,
  output logic [31:0] dat,
  output logic        req_wr
);
  logic        ack_q, ack_d, hit, unused_ok;
  logic [31:0] dat_q, dat_d, rdata;
  logic [7:0]  off;
  always_comb begin
    off = {adr[7:2], 2'b00};
    hit = stb & cyc & (adr[31:8] == BASE_ADDR[31:8]);
    ack_d = hit & ~ack_q;
    rdata = off == OFF_REQ ? req : off == OFF_CUR ? cur : off == OFF_STATUS ? status : off == OFF_ID ? id : '0;
    dat_d = ack_d & ~we ? rdata : '0;
    req_wr = ack_d & we & (off == OFF_REQ);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end
  assign unused_ok = ^adr[1:0];
  assign ack = ack_q;
  assign dat = dat_q;
endmodule

// File: rtl/wb_active_ctrl.sv
// wb_active_ctrl: wishbone-programmed project enables with a zero drain between selections
module wb_active_ctrl
  import wb_active_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int DRAIN_CYCLES = 16,
  parameter logic [31:0] ID_VALUE = 32'h5A2A_0001
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] active_o
);
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] req_q, req_d, cur_q, cur_d, act_q, act_d, status;
  logic        req_wr;
  wb_slave_if #(.BASE_ADDR(BASE_ADDR)) u_if (
    .clk(wb_clk_i),
    .rst_n(wb_rst_ni),
    .stb(wbs_stb_i),
    .cyc(wbs_cyc_i),
    .we(wbs_we_i),
    .adr(wbs_adr_i),
    .req(req_q),
    .cur(cur_q),
    .status(status),
    .id(ID_VALUE),
    .ack(wbs_ack_o),
    .dat(wbs_dat_o),
    .req_wr(req_wr)
  );
  always_comb begin
    for (int b = 0; b < 4; b++) req_d[8*b+:8] = req_wr & wbs_sel_i[b] ? wbs_dat_i[8*b+:8] : req_q[8*b+:8];
    status = '0;
    status[ST_BUSY] = state_q != IDLE;
    status[ST_PEND] = req_q != cur_q;
    state_d = state_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    act_d = act_q;
    case (state_q)
      IDLE: begin
        act_d = req_q != cur_q ? '0 : cur_q;
        state_d = req_q != cur_q ? DRAIN : IDLE;
        cnt_d = req_q != cur_q ? DRAIN_LOAD : cnt_q;
      end
      DRAIN: begin
        act_d = '0;
        cnt_d = req_wr ? DRAIN_LOAD : cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
        state_d = !req_wr && cnt_q == 8'd0 ? APPLY : DRAIN;
      end
      APPLY: begin
        cur_d = req_q;
        act_d = req_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= '0;
      cur_q <= '0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      cur_q <= cur_d;
      act_q <= act_d;
    end
  end
  assign active_o = act_q;
endmodule

// File: tb/tb_wb_active_ctrl.sv
// tb_wb_active_ctrl: table-driven and sequence checks of wb_active_ctrl with a read-data scoreboard
module tb_wb_active_ctrl;
  localparam int DRAIN = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID = 32'h5A2A_0001;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] exp;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_o, active;
  logic [31:0] exp_q[$];
  logic [31:0] prev_act = '0;
  int          nvec = 0, nerr = 0;
  vec_t        vecs[12];
  wb_active_ctrl #(.BASE_ADDR(BASE), .DRAIN_CYCLES(DRAIN), .ID_VALUE(ID)) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_dat_i(dat_i),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .active_o(active)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n && active !== prev_act) begin
      nvec++;
      if (prev_act != 0 && active != 0) begin
        nerr++;
        $display("FAIL active hop: went %h -> %h, required zero between", prev_act, active);
      end
    end
    prev_act = active;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic exp_ack, input logic [31:0] exp_d, input string name);
    int lat;
    logic got;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    if (exp_ack) exp_q.push_back(exp_d);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      lat = i;
      got = ack;
    end
    if (exp_ack) begin
      check({name, " ack latency"}, 32'(got ? lat : 0), 32'd1);
      check({name, " data"}, dat_o, exp_q.pop_front());
    end else check({name, " no ack"}, 32'(got), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (exp_ack) begin
      @(negedge clk);
      check({name, " ack width"}, 32'(ack), 32'd0);
    end
  endtask
  task automatic wait_active(input logic [31:0] exp, input int zeros, input string name);
    int z;
    z = 0;
    @(negedge clk);
    while (active === 32'h0 && z < 100) begin
      z++;
      @(negedge clk);
    end
    check({name, " active"}, active, exp);
    if (zeros >= 0) check({name, " zero cycles"}, 32'(z), 32'(zeros));
  endtask
  initial begin
    int bad;
    vecs[0]  = '{1'b0, BASE + 32'h0C, 32'h0, 4'hF, 1'b1, ID};
    vecs[1]  = '{1'b0, BASE + 32'h40, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, BASE + 32'h00, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, BASE + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, BASE + 32'h0F, 32'h0, 4'hF, 1'b1, ID};
    vecs[6]  = '{1'b1, BASE + 32'h04, 32'h1234, 4'hF, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, BASE + 32'h08, 32'hFFFF, 4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, BASE + 32'h80, 32'hFFFF, 4'hF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h2000_0000, 32'h0, 4'hF, 1'b0, 32'h0};
    vecs[10] = '{1'b1, BASE + 32'h100, 32'hFFFF, 4'hF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0};
    #12;
    check("reset ack", 32'(ack), 32'd0);
    check("reset dat", dat_o, 32'h0);
    check("reset active", active, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].ack, vecs[i].exp, $sformatf("vec%0d", i));
    xfer(1'b0, BASE, 32'h0, 4'hF, 1'b1, 32'h0, "req after miss write");
    xfer(1'b1, BASE, 32'hFFFF_FFFF, 4'b0010, 1'b1, 32'h0, "sel write");
    xfer(1'b0, BASE, 32'h0, 4'hF, 1'b1, 32'h0000_FF00, "sel req");
    xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, 1'b1, 32'h3, "status drain");
    xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0, "cur drain");
    wait_active(32'h0000_FF00, -1, "sel apply");
    xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0, "status idle");
    xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0000_FF00, "cur idle");
    xfer(1'b1, BASE, 32'h1, 4'hF, 1'b1, 32'h0, "write 1");
    wait_active(32'h1, DRAIN, "apply 1");
    xfer(1'b1, BASE, 32'h2, 4'hF, 1'b1, 32'h0, "write 2");
    repeat (6) @(negedge clk);
    xfer(1'b1, BASE, 32'h4, 4'hF, 1'b1, 32'h0, "write 4");
    wait_active(32'h4, DRAIN - 1, "apply 4");
    xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b1, 32'h4, "cur 4");
    xfer(1'b1, BASE, 32'h4, 4'hF, 1'b1, 32'h0, "write same");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (active !== 32'h4) bad++;
    end
    check("same write glitches", 32'(bad), 32'd0);
    xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0, "status same");
    xfer(1'b1, BASE, 32'h8, 4'hF, 1'b1, 32'h0, "write 8");
    repeat (5) @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h0C;
    @(negedge clk);
    check("ack before reset", 32'(ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset async ack", 32'(ack), 32'd0);
    check("reset async dat", dat_o, 32'h0);
    check("reset async active", active, 32'h0);
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0, "cur after reset");
    xfer(1'b0, BASE, 32'h0, 4'hF, 1'b1, 32'h0, "req after reset");
    xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 1'b1, ID, "id after reset");
    check("active after reset", active, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
